mult_rr_scheduler: RTL

- Round-robin scheduler that shares one MBE-Dadda multiplier (N x N unsigned, 2N product, LAT internal register stages) between NREQ requesters.
- Arbitrates valid/ready requests and registers the winning operands onto the multiplier inputs.
- Tracks in-flight operations with an ID shift pipeline and routes each registered product back to its requester as a one-hot response.
- Supports a drain/halt sequence so the multiplier can be quiesced, e.g. for reconfiguration or test.

---
 rtl/mult_rr_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mult_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : mult_rr_scheduler
//  Purpose  : Round-robin scheduler sharing one N x N unsigned multiplier
//             (LAT internal register stages) between NREQ requesters. Winning
//             operands are registered onto the multiplier inputs, an ID shift
//             pipeline tracks in-flight work and each product is returned to
//             its requester as a one-hot response. A drain/halt sequence lets
//             the multiplier be quiesced.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_valid/a/b     - per-requester operation and operands
//             req_ready         - one-hot (or zero) grant, combinational
//             mult_a/mult_b     - registered operands to the multiplier
//             mult_prod         - multiplier product (2N bits)
//             rsp_valid         - one-hot one-cycle response pulse
//             rsp_prod          - registered product
//             drain / halted    - quiesce request / quiesced indication
//             inflight          - accepted operations not yet responded
//  Revision : 1.0 - initial release
// ============================================================================
module mult_rr_scheduler #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int LAT  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [N-1:0]        mult_a,
    output logic [N-1:0]        mult_b,
    input  logic [2*N-1:0]      mult_prod,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [2*N-1:0]      rsp_prod,
    input  logic                drain,
    output logic                halted,
    output logic [2:0]          inflight
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_S_RUN    = 2'd0;
    localparam logic [1:0] c_S_DRAIN  = 2'd1;
    localparam logic [1:0] c_S_HALTED = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [N-1:0]        r_mult_a;
    logic [N-1:0]        r_mult_b;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [2*N-1:0]      r_rsp_prod;
    logic [2:0]          r_inflight;

    // Stage k holds the requester whose operands entered the multiplier k
    // edges ago; stage LAT lines up with the product on mult_prod.
    logic                r_pipe_vld [LAT+1];
    logic [c_PTR_W-1:0]  r_pipe_id  [LAT+1];

    logic                w_found;
    logic [c_PTR_W-1:0]  w_cand;
    logic [c_PTR_W-1:0]  w_grant_idx;
    logic [NREQ-1:0]     w_ready;
    logic                w_accept;
    logic [N-1:0]        w_sel_a;
    logic [N-1:0]        w_sel_b;

    // Rotating priority search starting at r_ptr.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = c_PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Grant only in RUN; reset also masks it so every output is zero in reset.
    assign w_ready  = (!rst && (r_state == c_S_RUN) && w_found) ?
                      (NREQ'(1) << w_grant_idx) : '0;
    assign w_accept = |w_ready;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == c_PTR_W'(k)) begin
                w_sel_a = req_a[k*N +: N];
                w_sel_b = req_b[k*N +: N];
            end
        end
    end

    // Drain release takes priority over completion so a dropped drain always
    // returns straight to RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_RUN: begin
                if (drain) w_next_state = c_S_DRAIN;
            end
            c_S_DRAIN: begin
                if (!drain)                  w_next_state = c_S_RUN;
                else if (r_inflight == 3'd0) w_next_state = c_S_HALTED;
            end
            c_S_HALTED: begin
                if (!drain) w_next_state = c_S_RUN;
            end
            default: w_next_state = c_S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_RUN;
            r_ptr       <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_rsp_valid <= '0;
            r_rsp_prod  <= '0;
            r_inflight  <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_pipe_vld[s] <= 1'b0;
                r_pipe_id[s]  <= '0;
            end
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                r_ptr    <= (w_grant_idx == c_PTR_W'(NREQ - 1)) ? '0 :
                            w_grant_idx + c_PTR_W'(1);
                r_mult_a <= w_sel_a;
                r_mult_b <= w_sel_b;
            end

            r_pipe_vld[0] <= w_accept;
            r_pipe_id[0]  <= w_grant_idx;
            for (int s = 1; s <= LAT; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_id[s]  <= r_pipe_id[s-1];
            end

            if (r_pipe_vld[LAT]) begin
                r_rsp_valid <= NREQ'(1) << r_pipe_id[LAT];
                r_rsp_prod  <= mult_prod;
            end else begin
                r_rsp_valid <= '0;
            end

            // Accept and response on the same edge cancel out.
            r_inflight <= r_inflight + {2'b00, w_accept}
                                     - {2'b00, r_pipe_vld[LAT]};
        end
    end

    assign req_ready = w_ready;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_prod  = r_rsp_prod;
    assign halted    = (r_state == c_S_HALTED);
    assign inflight  = r_inflight;

endmodule
`default_nettype wire
